// File: rtl/qspi_target_if.sv
// qspi_target_if: user-side signals of the QSPI target, grouped into one bundle.
//   master modport : user logic (drives mode/direction/TX byte, observes results)
//   slave modport  : qspi_target (consumes mode/direction/TX byte, reports RX
//                    data, load/valid/abort pulses and busy)
// Signals:
//   i_q_mode   1 = quad, 0 = single (sampled at CS assertion)
//   i_tx_en    1 = target transmits this transaction (sampled at CS assertion)
//   i_tx_data  next byte to transmit
//   o_tx_dload 1-cycle pulse, i_tx_data captured into the TX shifter
//   o_rx_data  last complete received byte
//   o_rx_dval  1-cycle pulse, o_rx_data updated
//   o_busy     high while synchronized CS is active
//   o_abort    1-cycle pulse, CS released with a partial byte
`timescale 1ns/1ps
interface qspi_target_if;
  logic       i_q_mode;
  logic       i_tx_en;
  logic [7:0] i_tx_data;
  logic       o_tx_dload;
  logic [7:0] o_rx_data;
  logic       o_rx_dval;
  logic       o_busy;
  logic       o_abort;

  modport master (
    output i_q_mode, i_tx_en, i_tx_data,
    input  o_tx_dload, o_rx_data, o_rx_dval, o_busy, o_abort
  );

  modport slave (
    input  i_q_mode, i_tx_en, i_tx_data,
    output o_tx_dload, o_rx_data, o_rx_dval, o_busy, o_abort
  );
endinterface

// File: rtl/qspi_target.sv
// qspi_target: single-clock QSPI responder, SPI mode 0, MSB first, single
// (1-bit) or quad (4-bit) lanes. i_sclk and i_cs are oversampled in the clk
// domain; all serial activity is driven from the resulting edge pulses.
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset
//   user    qspi_target_if.slave user-side bundle (mode, TX byte, RX byte,
//           load/valid/abort pulses, busy)
//   i_sclk  controller serial clock, idle low
//   i_cs    controller chip select, active low
//   SIO     serial data lanes; single mode uses SIO[0] in, SIO[1] out
// Parameter:
//   SYNC_STAGES  synchronizer depth for i_sclk/i_cs (>= 2)
`timescale 1ns/1ps
module qspi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  qspi_target_if.slave user,
  input  logic         i_sclk,
  input  logic         i_cs,
  inout  wire  [3:0]   SIO
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t     state;
  logic       q;
  logic       tx;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic       byte_done;
  logic [7:0] rx_data;
  logic       rx_dval;
  logic       tx_dload;
  logic       abort;
  logic       busy;
  logic [3:0] sio_oe;
  logic [3:0] sio_do;
  logic       cnt_wrap;
  logic [7:0] rx_next;

  // Synchronizers reset to the bus idle levels (sclk low, cs high) so that
  // leaving reset with an idle bus produces no spurious edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // A byte spans 2 rising edges in quad mode and 8 in single mode.
  assign cnt_wrap = q ? (bit_cnt == 3'd1) : (bit_cnt == 3'd7);

  // New bits enter at the LSB end, so the first quad nibble ends up in [7:4].
  assign rx_next = q ? {rx_sr[3:0], SIO} : {rx_sr[6:0], SIO[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= 1'b0;
      tx        <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sr     <= 8'h00;
      tx_sr     <= 8'h00;
      byte_done <= 1'b0;
      rx_data   <= 8'h00;
      rx_dval   <= 1'b0;
      tx_dload  <= 1'b0;
      abort     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_dval  <= 1'b0;
      tx_dload <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            q         <= user.i_q_mode;
            tx        <= user.i_tx_en;
            bit_cnt   <= 3'd0;
            rx_sr     <= 8'h00;
            byte_done <= 1'b0;
            busy      <= 1'b1;
            if (user.i_tx_en) begin
              tx_sr    <= user.i_tx_data;
              tx_dload <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // CS release takes priority; a coincident sclk rise is dropped.
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            if (bit_cnt != 3'd0) begin
              abort <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              bit_cnt   <= cnt_wrap ? 3'd0 : bit_cnt + 3'd1;
              byte_done <= cnt_wrap;
              if (!tx) begin
                rx_sr <= rx_next;
                if (cnt_wrap) begin
                  rx_data <= rx_next;
                  rx_dval <= 1'b1;
                end
              end
            end
            // The fall after a byte-completing rise reloads rather than shifts.
            if (sclk_fall && tx) begin
              if (byte_done) begin
                tx_sr     <= user.i_tx_data;
                tx_dload  <= 1'b1;
                byte_done <= 1'b0;
              end else begin
                tx_sr <= q ? {tx_sr[3:0], 4'h0} : {tx_sr[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pad drive is registered one cycle behind the shifter so lanes change
  // cleanly; reset clears the enables immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sio_oe <= 4'h0;
      sio_do <= 4'h0;
    end else begin
      if (state == ACTIVE && tx) begin
        sio_oe <= q ? 4'hF : 4'b0010;
      end else begin
        sio_oe <= 4'h0;
      end
      sio_do <= q ? tx_sr[7:4] : {2'b00, tx_sr[7], 1'b0};
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_sio
    assign SIO[i] = sio_oe[i] ? sio_do[i] : 1'bz;
  end

  assign user.o_rx_data  = rx_data;
  assign user.o_rx_dval  = rx_dval;
  assign user.o_tx_dload = tx_dload;
  assign user.o_abort    = abort;
  assign user.o_busy     = busy;

endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: self-checking bench for qspi_target. Acts as the QSPI
// controller and the user-side logic, runs a table of directed transactions,
// hand-written reset and CS/SCLK collision sequences, and randomized
// transactions checked against a byte/bit-stream reference model.
// SIO carries pull-ups, so an undriven lane reads as 1.
`timescale 1ns/1ps
module tb_qspi_target;

  localparam int HALF = 6;

  typedef struct {
    bit         q;
    bit         tx;
    int         nbytes;
    int         extra;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         exp_nrx;
    logic [15:0] exp_rx;
    int         exp_abort;
    int         exp_dload;
    logic [23:0] exp_stream;
  } vec_t;

  typedef struct {
    int          nrx;
    logic [15:0] rx;
    int          nabort;
    int          ndload;
    logic [23:0] stream;
    bit          z_ok;
    logic        busy_mid;
    logic        busy_hold;
    logic        busy_drop;
  } act_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sclk = 1'b0;
  logic       i_cs = 1'b1;
  logic [3:0] ctl_oe = 4'h0;
  logic [3:0] ctl_do = 4'h0;
  wire  [3:0] sio;

  int pass_cnt = 0;
  int total_cnt = 0;
  int dload_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] rx_q[$];

  qspi_target_if u_if ();

  always #10 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_bus
    pullup (sio[g]);
    assign sio[g] = ctl_oe[g] ? ctl_do[g] : 1'bz;
  end

  qspi_target #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .user   (u_if),
    .i_sclk (i_sclk),
    .i_cs   (i_cs),
    .SIO    (sio)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.o_rx_dval)  rx_q.push_back(u_if.o_rx_data);
      if (u_if.o_tx_dload) dload_cnt++;
      if (u_if.o_abort)    abort_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] bitsAt(input logic [23:0] bytes, input int k, input int w);
    logic [23:0] t;
    t = bytes >> (24 - (k + 1) * w);
    return (w == 4) ? t[3:0] : {3'b000, t[0]};
  endfunction

  // Reference model: a transaction is a stream of rises*W bits taken MSB
  // first from b0,b1,b2; every 8 bits is one byte.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int w, per, rises, done;
    r     = v;
    w     = v.q ? 4 : 1;
    per   = 8 / w;
    rises = v.nbytes * per + v.extra;
    done  = (rises * w) / 8;
    r.exp_nrx    = v.tx ? 0 : done;
    r.exp_rx     = {v.b0, v.b1};
    r.exp_abort  = ((rises * w) % 8 != 0) ? 1 : 0;
    r.exp_dload  = v.tx ? done + 1 : 0;
    r.exp_stream = v.tx ? ({v.b0, v.b1, v.b2} >> (24 - rises * w)) : 24'h0;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, output act_t a);
    int w, per, rises, rx0, dl0, ab0;
    logic [23:0] bytes;
    logic [7:0]  tb_b[4];
    w     = v.q ? 4 : 1;
    per   = 8 / w;
    rises = v.nbytes * per + v.extra;
    bytes = {v.b0, v.b1, v.b2};
    tb_b[0] = v.b0;
    tb_b[1] = v.b1;
    tb_b[2] = v.b2;
    tb_b[3] = 8'($urandom);
    rx0 = rx_q.size();
    dl0 = dload_cnt;
    ab0 = abort_cnt;
    a.stream = '0;
    a.rx     = '0;
    a.z_ok   = 1'b1;
    @(posedge clk); #1;
    u_if.i_q_mode  = v.q;
    u_if.i_tx_en   = v.tx;
    u_if.i_tx_data = v.b0;
    i_cs = 1'b0;
    if (!v.tx) begin
      ctl_oe = v.q ? 4'hF : 4'h1;
      ctl_do = bitsAt(bytes, 0, w);
    end
    repeat (HALF) @(posedge clk); #1;
    for (int k = 0; k < rises; k++) begin
      i_sclk = 1'b1;
      if (v.tx) begin
        a.stream = v.q ? {a.stream[19:0], sio} : {a.stream[22:0], sio[1]};
        if (!v.q && {sio[3:2], sio[0]} !== 3'b111) a.z_ok = 1'b0;
        if (k % per == 0) u_if.i_tx_data = tb_b[k / per + 1];
      end else if (!v.q && sio[3:1] !== 3'b111) begin
        a.z_ok = 1'b0;
      end
      repeat (HALF) @(posedge clk); #1;
      i_sclk = 1'b0;
      if (!v.tx && k + 1 < rises) ctl_do = bitsAt(bytes, k + 1, w);
      repeat (HALF) @(posedge clk); #1;
    end
    a.busy_mid = u_if.o_busy;
    i_cs   = 1'b1;
    ctl_oe = 4'h0;
    repeat (3) @(negedge clk);
    a.busy_hold = u_if.o_busy;
    @(negedge clk);
    a.busy_drop = u_if.o_busy;
    repeat (4) @(negedge clk);
    if (sio !== 4'hF) a.z_ok = 1'b0;
    a.nrx = rx_q.size() - rx0;
    if (a.nrx > 0) a.rx[15:8] = rx_q[rx0];
    if (a.nrx > 1) a.rx[7:0]  = rx_q[rx0 + 1];
    a.ndload = dload_cnt - dl0;
    a.nabort = abort_cnt - ab0;
  endtask

  task automatic checkVector(input string tag, input vec_t v, input act_t a);
    checkOutput($sformatf("%s_nrx", tag), a.nrx, v.exp_nrx);
    if (v.exp_nrx > 0) checkOutput($sformatf("%s_rx0", tag), {24'h0, a.rx[15:8]}, {24'h0, v.exp_rx[15:8]});
    if (v.exp_nrx > 1) checkOutput($sformatf("%s_rx1", tag), {24'h0, a.rx[7:0]}, {24'h0, v.exp_rx[7:0]});
    checkOutput($sformatf("%s_abort", tag), a.nabort, v.exp_abort);
    checkOutput($sformatf("%s_dload", tag), a.ndload, v.exp_dload);
    if (v.tx) checkOutput($sformatf("%s_stream", tag), {8'h0, a.stream}, {8'h0, v.exp_stream});
    checkOutput($sformatf("%s_sio_z", tag), {31'h0, a.z_ok}, 32'h1);
    checkOutput($sformatf("%s_busy_mid", tag), {31'h0, a.busy_mid}, 32'h1);
    checkOutput($sformatf("%s_busy_hold", tag), {31'h0, a.busy_hold}, 32'h1);
    checkOutput($sformatf("%s_busy_drop", tag), {31'h0, a.busy_drop}, 32'h0);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    act_t a;
    int ab0, rxn0;

    //          q  tx nb ex  b0     b1     b2     nrx rx        ab dl stream
    tbl[0] = '{1, 0, 2, 0, 8'hAA, 8'h5A, 8'h00, 2, 16'hAA5A, 0, 0, 24'h0};
    tbl[1] = '{1, 1, 2, 0, 8'h55, 8'hA5, 8'h00, 0, 16'h0000, 0, 3, 24'h0055A5};
    tbl[2] = '{0, 0, 1, 0, 8'hAA, 8'h00, 8'h00, 1, 16'hAA00, 0, 0, 24'h0};
    tbl[3] = '{0, 1, 1, 0, 8'h55, 8'h00, 8'h00, 0, 16'h0000, 0, 2, 24'h000055};
    tbl[4] = '{0, 0, 0, 3, 8'hAA, 8'h00, 8'h00, 0, 16'h0000, 1, 0, 24'h0};
    tbl[5] = '{0, 0, 1, 0, 8'h3C, 8'h00, 8'h00, 1, 16'h3C00, 0, 0, 24'h0};
    tbl[6] = '{1, 1, 1, 1, 8'h96, 8'h7E, 8'h00, 0, 16'h0000, 1, 2, 24'h000967};

    u_if.i_q_mode  = 1'b0;
    u_if.i_tx_en   = 1'b0;
    u_if.i_tx_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",  {31'h0, u_if.o_busy}, 32'h0);
    checkOutput("reset_rx",    {24'h0, u_if.o_rx_data}, 32'h0);
    checkOutput("reset_dval",  {31'h0, u_if.o_rx_dval}, 32'h0);
    checkOutput("reset_dload", {31'h0, u_if.o_tx_dload}, 32'h0);
    checkOutput("reset_abort", {31'h0, u_if.o_abort}, 32'h0);
    checkOutput("reset_sio",   {28'h0, sio}, 32'hF);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i], a);
      checkVector($sformatf("vec%0d", i), tbl[i], a);
    end

    // Reset in the middle of a quad read: lanes must release on the next cycle.
    ab0 = abort_cnt;
    @(posedge clk); #1;
    u_if.i_q_mode  = 1'b1;
    u_if.i_tx_en   = 1'b1;
    u_if.i_tx_data = 8'h21;
    i_cs = 1'b0;
    repeat (HALF) @(posedge clk); #1;
    i_sclk = 1'b1;
    repeat (HALF) @(posedge clk); #1;
    i_sclk = 1'b0;
    repeat (HALF) @(posedge clk); #1;
    checkOutput("rstseq_pre_sio", {28'h0, sio}, 32'h1);
    rst_n  = 1'b0;
    i_cs   = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstseq_sio",   {28'h0, sio}, 32'hF);
    checkOutput("rstseq_busy",  {31'h0, u_if.o_busy}, 32'h0);
    checkOutput("rstseq_rx",    {24'h0, u_if.o_rx_data}, 32'h0);
    checkOutput("rstseq_dval",  {31'h0, u_if.o_rx_dval}, 32'h0);
    checkOutput("rstseq_dload", {31'h0, u_if.o_tx_dload}, 32'h0);
    checkOutput("rstseq_abort", {31'h0, u_if.o_abort}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rstseq_no_abort", abort_cnt - ab0, 0);
    v = '{1, 1, 1, 0, 8'hF0, 8'h00, 8'h00, 0, 16'h0000, 0, 2, 24'h0000F0};
    applyStimulus(v, a);
    checkVector("rstseq_f0", v, a);

    // CS release coinciding with the 8th sclk rise: the rise must be dropped.
    ab0  = abort_cnt;
    rxn0 = rx_q.size();
    @(posedge clk); #1;
    u_if.i_q_mode = 1'b0;
    u_if.i_tx_en  = 1'b0;
    i_cs   = 1'b0;
    ctl_oe = 4'h1;
    ctl_do = bitsAt(24'hC30000, 0, 1);
    repeat (HALF) @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      i_sclk = 1'b1;
      repeat (HALF) @(posedge clk); #1;
      i_sclk = 1'b0;
      ctl_do = bitsAt(24'hC30000, k + 1, 1);
      repeat (HALF) @(posedge clk); #1;
    end
    i_sclk = 1'b1;
    i_cs   = 1'b1;
    ctl_oe = 4'h0;
    repeat (10) @(posedge clk); #1;
    i_sclk = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("collide_abort", abort_cnt - ab0, 1);
    checkOutput("collide_no_dval", rx_q.size() - rxn0, 0);
    checkOutput("collide_busy", {31'h0, u_if.o_busy}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      int per;
      v.q      = 1'($urandom_range(0, 1));
      v.tx     = 1'($urandom_range(0, 1));
      v.nbytes = $urandom_range(1, 2);
      per      = v.q ? 2 : 8;
      v.extra  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, per - 1) : 0;
      v.b0     = 8'($urandom);
      v.b1     = 8'($urandom);
      v.b2     = 8'($urandom);
      v = model(v);
      applyStimulus(v, a);
      checkVector($sformatf("rand%0d", i), v, a);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
